lpffir_arbiter: RTL
===================

LPFFIR_ARBITER -- requirements
Module: lpffir_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, sample width of every tdata port.
REQ-002 Parameter TAG_DEPTH, default 4, entries in the in-flight channel-tag FIFO; power of two, at least 2.
REQ-003 aclk_i  in  1  single clock; all logic on rising edge.
REQ-004 aresetn_i  in  1  reset, asynchronous, active-low.
REQ-005 s{0,1}_tdata_i  in  DATA_W  requester sample input, channel 0/1.
REQ-006 s{0,1}_tvalid_i, s{0,1}_tlast_i  in  1  requester valid / end-of-packet.
REQ-007 s{0,1}_tready_o  out  1  requester ready.
REQ-008 core_rx_tdata_o  out  DATA_W; core_rx_tvalid_o, core_rx_tlast_o  out  1  stream into the shared FIR core.
REQ-009 core_rx_tready_i  in  1  FIR core input ready.
REQ-010 core_tx_tdata_i  in  DATA_W; core_tx_tvalid_i, core_tx_tlast_i  in  1  FIR core filtered output.
REQ-011 core_tx_tready_o  out  1  ready back to the FIR core.
REQ-012 m{0,1}_tdata_o  out  DATA_W; m{0,1}_tvalid_o, m{0,1}_tlast_o  out  1  filtered output per channel.
REQ-013 m{0,1}_tready_i  in  1  downstream ready per channel.
REQ-014 grant_o  out  2  one-hot current input owner; 00 when idle.
REQ-015 err_o  out  1  sticky flag: core output beat arrived with an empty tag FIFO.

Function
REQ-016 Arbiter FSM SHALL have states IDLE and LOCK, with owner register owner_q and last-owner register last_q.
REQ-017 IDLE: if either s*_tvalid_i is high and the tag FIFO is not full, the FSM SHALL register owner = round-robin pick (channel != last_q preferred when both are valid) and enter LOCK next cycle; arbitration costs exactly 1 cycle.
REQ-018 LOCK: core_rx_* SHALL combinationally mirror s[owner]_*; s[owner]_tready_o = core_rx_tready_i AND NOT fifo_full; the non-owner tready_o = 0.
REQ-019 core_rx_tvalid_o SHALL be 0 in IDLE and whenever the tag FIFO is full, so that no beat is accepted without a free tag.
REQ-020 An accepted input beat (core_rx_tvalid_o AND core_rx_tready_i) SHALL push owner_q into the tag FIFO in the same cycle.
REQ-021 An accepted beat with tlast = 1 SHALL return the FSM to IDLE and set last_q = owner_q; the grant is held for the whole packet, including across stalls of any length.
REQ-022 Output routing: when the FIFO is non-empty with head h, m[h]_* = core_tx_* and core_tx_tready_o = m[h]_tready_i; the other channel's m_tvalid_o = 0.
REQ-023 A core output handshake SHALL pop one tag; push and pop in the same cycle leave the count unchanged.
REQ-024 FIFO count range is 0..TAG_DEPTH; pointers wrap modulo TAG_DEPTH; a push is never attempted at full (gated by REQ-019).
REQ-025 core_tx_tvalid_i = 1 with an empty FIFO SHALL drive core_tx_tready_o = 1 (beat discarded), keep both m*_tvalid_o = 0, and set err_o.
REQ-026 The data path SHALL add zero cycles of latency; tdata and tlast pass unmodified at DATA_W.

Reset
REQ-027 Reset asserted SHALL force, asynchronously: state IDLE, owner_q = 0, last_q = 1 (channel 0 wins first), FIFO empty, err_o = 0, grant_o = 00, and all tready_o/tvalid_o outputs = 0.
REQ-028 Reset in mid-packet SHALL abandon the packet and in-flight tags; after release, behaviour SHALL be as from power-up.

Structure
REQ-029 Package lpffir_pkg SHALL hold DATA_W default, arb_state_t enum {IDLE, LOCK} and chan_id_t (1 bit).
REQ-030 The tag FIFO SHALL be a sub-module lpffir_tag_fifo (push, pop, full, empty, head).

Verification
REQ-031 Only s0 sends 6 beats of 50..100 with tlast on beat 6, core as pass-through -> grant_o=01 from cycle 2, all 6 beats appear on m0, m1_tvalid_o stays 0, FSM returns to IDLE.
REQ-032 s0 and s1 both valid from reset with 3-beat packets -> order is s0 packet, then s1 packet, then s0 packet; no interleaving within a packet.
REQ-033 Core with 3-cycle latency, m0_tready_i held 0 -> exactly 4 beats accepted, then core_rx_tvalid_o=0; raising m0_tready_i resumes the flow with no loss.
REQ-034 s1 packet in flight while core output for an s0 beat is still pending -> that beat is routed to m0 and later beats to m1, per tag order.
REQ-035 Pulse core_tx_tvalid_i with an empty FIFO -> err_o=1 and stays 1; m0/m1 tvalid stay 0.
REQ-036 Assert aresetn_i low mid-packet, on a non-clock edge -> all outputs 0 immediately; after release the first grant goes to s0.

Source files
------------

// File: rtl/lpffir_arbiter_pkg.sv
// Shared types for the two-channel front end of the shared low-pass FIR core.
// This covers the FSM state, the channel id and a one-hot helper for the grant output.
package lpffir_pkg;

  localparam int LPFFIR_DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef logic [0:0] chan_id_t;

  function automatic logic [1:0] chan_onehot(chan_id_t c);
    return c[0] ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lpffir_arbiter_if.sv
// AXI-Stream style beat channel (data, valid, last, ready).
// The module that drives data uses master; the module that consumes it uses slave.
interface lpffir_arbiter_if
  import lpffir_pkg::*;
#(
  parameter int DATA_W = LPFFIR_DATA_W
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/lpffir_arbiter_tag_fifo.sv
// In-flight channel-tag FIFO: records which requester owns each beat inside the FIR core.
// DEPTH must be a power of two so that the pointers wrap naturally.
module lpffir_tag_fifo
  import lpffir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     aclk_i,
  input  logic     aresetn_i,
  input  logic     push,
  input  chan_id_t push_tag,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output chan_id_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  chan_id_t         mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage is qualified by count, so it needs no reset.
  always_ff @(posedge aclk_i) begin
    if (push_ok) mem[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/lpffir_arbiter.sv
// Two-requester packet arbiter in front of one shared FIR core, with tag-ordered output routing.
// Grants are held per packet, data passes with zero added latency, and core beats arriving with no tag raise err_o.
module lpffir_arbiter
  import lpffir_pkg::*;
#(
  parameter int DATA_W    = LPFFIR_DATA_W,
  parameter int TAG_DEPTH = 4
) (
  input  logic             aclk_i,
  input  logic             aresetn_i,
  lpffir_arbiter_if.slave  s0,
  lpffir_arbiter_if.slave  s1,
  lpffir_arbiter_if.master core_rx,
  lpffir_arbiter_if.slave  core_tx,
  lpffir_arbiter_if.master m0,
  lpffir_arbiter_if.master m1,
  output logic [1:0]       grant_o,
  output logic             err_o
);

  arb_state_t        state_q, state_d;
  chan_id_t          owner_q, owner_d;
  chan_id_t          last_q, last_d;

  logic              fifo_full;
  logic              fifo_empty;
  chan_id_t          fifo_head;

  logic [DATA_W-1:0] sel_tdata;
  logic              sel_tvalid;
  logic              sel_tlast;
  logic              lock;
  logic              rx_ready;
  logic              rx_accept;
  logic              tx_pop;

  always_comb begin
    if (owner_q == 1'b1) begin
      sel_tdata  = s1.tdata;
      sel_tvalid = s1.tvalid;
      sel_tlast  = s1.tlast;
    end else begin
      sel_tdata  = s0.tdata;
      sel_tvalid = s0.tvalid;
      sel_tlast  = s0.tlast;
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Round-robin favours the channel that did not send the previous packet.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if ((s0.tvalid || s1.tvalid) && !fifo_full) begin
          state_d = LOCK;
          owner_d = (s0.tvalid && s1.tvalid) ? ~last_q : chan_id_t'(s1.tvalid);
        end
      end
      LOCK: begin
        if (rx_accept && sel_tlast) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lock     = (state_q == LOCK);
  assign grant_o  = lock ? chan_onehot(owner_q) : 2'b00;

  // A full tag FIFO stalls the core input so every accepted beat gets a tag.
  assign core_rx.tdata  = sel_tdata;
  assign core_rx.tlast  = sel_tlast;
  assign core_rx.tvalid = lock & sel_tvalid & ~fifo_full;
  assign rx_ready       = lock & core_rx.tready & ~fifo_full;
  assign s0.tready      = rx_ready & ~owner_q[0];
  assign s1.tready      = rx_ready & owner_q[0];
  assign rx_accept      = core_rx.tvalid & core_rx.tready;

  assign m0.tdata  = core_tx.tdata;
  assign m0.tlast  = core_tx.tlast;
  assign m1.tdata  = core_tx.tdata;
  assign m1.tlast  = core_tx.tlast;
  assign m0.tvalid = core_tx.tvalid & ~fifo_empty & ~fifo_head[0];
  assign m1.tvalid = core_tx.tvalid & ~fifo_empty & fifo_head[0];

  // Untagged core beats are swallowed; the reset term keeps ready low while held in reset.
  assign core_tx.tready = aresetn_i &
                          (fifo_empty ? 1'b1 : (fifo_head[0] ? m1.tready : m0.tready));
  assign tx_pop         = core_tx.tvalid & core_tx.tready & ~fifo_empty;

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i)                         err_o <= 1'b0;
    else if (core_tx.tvalid && fifo_empty)  err_o <= 1'b1;
  end

  lpffir_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .aclk_i    (aclk_i),
    .aresetn_i (aresetn_i),
    .push      (rx_accept),
    .push_tag  (owner_q),
    .pop       (tx_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule
